// File: rtl/pong_ball_engine.sv
// Pong ball physics and scoring: tick-divided motion, wall/paddle reflection, point pause, game over.
// Optional macro BALL_SPEEDUP_EN: ball step grows by one per paddle hit (1..4), back to 1 after a point.
module pong_ball_engine #(
    parameter int DIV_BITS    = 17,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int LEFT_X      = 20,
    parameter int RIGHT_X     = 620,
    parameter int PAD_HALF    = 10,
    parameter int PAUSE_TICKS = 64,
    parameter int WIN_SCORE   = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [9:0] paddle_l_y,
    input  logic [9:0] paddle_r_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over
);
    localparam logic [9:0] CX    = 10'(SCREEN_W / 2);
    localparam logic [9:0] CY    = 10'(SCREEN_H / 2);
    localparam logic [9:0] Y_MAX = 10'(SCREEN_H - 1);
    localparam logic [9:0] LX    = 10'(LEFT_X);
    localparam logic [9:0] RX    = 10'(RIGHT_X);
    localparam logic [3:0] WIN   = 4'(WIN_SCORE);
    localparam int         PW    = $clog2(PAUSE_TICKS + 1);
    localparam logic [PW-1:0] PAUSE_LAST = PW'(PAUSE_TICKS - 1);
    localparam logic signed [10:0] PH = 11'(PAD_HALF);

    typedef enum logic [1:0] {IDLE, PLAY, POINT, OVER} state_t;

    state_t              state_q, state_d;
    logic [DIV_BITS-1:0] div_q;
    logic                tick;
    logic [9:0]          x_q, x_d, y_q, y_d;
    logic                dx_right_q, dx_right_d, dy_down_q, dy_down_d;
    logic [3:0]          sl_q, sl_d, sr_q, sr_d;
    logic [PW-1:0]       pause_q, pause_d;
    logic [2:0]          step;
    logic [9:0]          step_w;
    logic                step_inc, step_clr;
    logic [9:0]          y_new;
    logic                dy_new;
    logic                hit_l, hit_r;

    // Inclusive paddle window test on an 11-bit signed difference.
    function automatic logic in_window(input logic [9:0] ball, input logic [9:0] pad);
        logic signed [10:0] diff;
        diff = $signed({1'b0, ball}) - $signed({1'b0, pad});
        return (diff <= PH) && (diff >= -PH);
    endfunction

`ifdef BALL_SPEEDUP_EN
    function automatic logic [2:0] sat_step(input logic [2:0] s);
        return (s >= 3'd4) ? 3'd4 : s + 3'd1;
    endfunction

    logic [2:0] step_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        step_q <= 3'd1;
        else if (step_clr) step_q <= 3'd1;
        else if (step_inc) step_q <= sat_step(step_q);
    end

    assign step = step_q;
`else
    logic unused_step_ctl;
    assign unused_step_ctl = step_inc ^ step_clr;
    assign step = 3'd1;
`endif

    assign step_w = {7'd0, step};
    assign tick   = &div_q;

    // Vertical move with wall clamp; also feeds the paddle window test of the same tick.
    always_comb begin
        y_new  = y_q;
        dy_new = dy_down_q;
        if (!dy_down_q) begin
            if (y_q < step_w) begin
                y_new  = 10'd0;
                dy_new = 1'b1;
            end else begin
                y_new = y_q - step_w;
            end
        end else begin
            if (y_q > Y_MAX - step_w) begin
                y_new  = Y_MAX;
                dy_new = 1'b0;
            end else begin
                y_new = y_q + step_w;
            end
        end
        hit_l = in_window(y_new, paddle_l_y);
        hit_r = in_window(y_new, paddle_r_y);
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        dx_right_d = dx_right_q;
        dy_down_d  = dy_down_q;
        sl_d       = sl_q;
        sr_d       = sr_q;
        pause_d    = pause_q;
        step_inc   = 1'b0;
        step_clr   = 1'b0;
        case (state_q)
            IDLE: begin
                x_d = CX;
                y_d = CY;
                if (start) state_d = PLAY;
            end
            PLAY: begin
                if (tick) begin
                    y_d       = y_new;
                    dy_down_d = dy_new;
                    if (!dx_right_q && (x_q <= LX + step_w)) begin
                        if (hit_l) begin
                            x_d        = LX;
                            dx_right_d = 1'b1;
                            step_inc   = 1'b1;
                        end else begin
                            sr_d       = sr_q + 4'd1;
                            x_d        = CX;
                            y_d        = CY;
                            dx_right_d = 1'b0;
                            step_clr   = 1'b1;
                            state_d    = POINT;
                        end
                    end else if (dx_right_q && (x_q >= RX - step_w)) begin
                        if (hit_r) begin
                            x_d        = RX;
                            dx_right_d = 1'b0;
                            step_inc   = 1'b1;
                        end else begin
                            sl_d       = sl_q + 4'd1;
                            x_d        = CX;
                            y_d        = CY;
                            dx_right_d = 1'b1;
                            step_clr   = 1'b1;
                            state_d    = POINT;
                        end
                    end else begin
                        x_d = dx_right_q ? x_q + step_w : x_q - step_w;
                    end
                end
            end
            POINT: begin
                x_d = CX;
                y_d = CY;
                if (tick) begin
                    if (pause_q == PAUSE_LAST) begin
                        pause_d = '0;
                        state_d = (sl_q == WIN || sr_q == WIN) ? OVER : PLAY;
                    end else begin
                        pause_d = pause_q + PW'(1);
                    end
                end
            end
            OVER: begin
                x_d = CX;
                y_d = CY;
                if (start) begin
                    sl_d       = 4'd0;
                    sr_d       = 4'd0;
                    dx_right_d = 1'b1;
                    dy_down_d  = 1'b1;
                    step_clr   = 1'b1;
                    state_d    = PLAY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_q      <= '0;
            x_q        <= CX;
            y_q        <= CY;
            dx_right_q <= 1'b1;
            dy_down_q  <= 1'b1;
            sl_q       <= 4'd0;
            sr_q       <= 4'd0;
            pause_q    <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_q + DIV_BITS'(1);
            x_q        <= x_d;
            y_q        <= y_d;
            dx_right_q <= dx_right_d;
            dy_down_q  <= dy_down_d;
            sl_q       <= sl_d;
            sr_q       <= sr_d;
            pause_q    <= pause_d;
        end
    end

    assign ball_x    = x_q;
    assign ball_y    = y_q;
    assign score_l   = sl_q;
    assign score_r   = sr_q;
    assign game_over = (state_q == OVER);
endmodule

// File: tb/tb_pong_ball_engine.sv
// Self-checking bench for pong_ball_engine (DIV_BITS=2) against a tick-level game model.
module tb_pong_ball_engine;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [9:0] pl    = 10'd10;
    logic [9:0] pr    = 10'd10;
    logic [9:0] bx, by;
    logic [3:0] sl, sr;
    logic       go;

    int checks   = 0;
    int failures = 0;

`ifdef BALL_SPEEDUP_EN
    localparam int MAX_STEP = 4;
`else
    localparam int MAX_STEP = 1;
`endif

    pong_ball_engine #(.DIV_BITS(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .paddle_l_y(pl), .paddle_r_y(pr),
        .ball_x(bx), .ball_y(by), .score_l(sl), .score_r(sr), .game_over(go)
    );

    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_PLAY, M_POINT, M_OVER} mst_t;
    mst_t m_st;
    int   m_x, m_y, m_dx, m_dy, m_sl, m_sr, m_pause, m_step, m_clk, m_hits;
    bit   m_tick;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int clampv(input int v);
        return (v < 10) ? 10 : (v > 470) ? 470 : v;
    endfunction

    // An overshoot past a wall lands on the wall and reverses.
    function automatic void vnext(input int y, input int dy, input int s, output int ny, output int ndy);
        ny  = y + dy * s;
        ndy = dy;
        if (ny < 0)        begin ny = 0;   ndy = 1;  end
        else if (ny > 479) begin ny = 479; ndy = -1; end
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_x = 320; m_y = 240; m_dx = 1; m_dy = 1;
        m_sl = 0; m_sr = 0; m_pause = 0; m_step = 1; m_clk = 0; m_hits = 0; m_tick = 0;
    endtask

    task automatic model_miss(input int serve_dir);
        m_x = 320; m_y = 240; m_dx = serve_dir; m_step = 1; m_st = M_POINT;
    endtask

    task automatic model_play_tick();
        int ny, ndy, nx;
        vnext(m_y, m_dy, m_step, ny, ndy);
        m_y = ny; m_dy = ndy;
        nx = m_x + m_dx * m_step;
        if (m_dx < 0 && nx <= 20) begin
            if (iabs(ny - int'(pl)) <= 10) begin
                m_x = 20; m_dx = 1; m_hits++;
                m_step = (m_step + 1 > MAX_STEP) ? MAX_STEP : m_step + 1;
            end else begin
                m_sr++; model_miss(-1);
            end
        end else if (m_dx > 0 && nx >= 620) begin
            if (iabs(ny - int'(pr)) <= 10) begin
                m_x = 620; m_dx = -1; m_hits++;
                m_step = (m_step + 1 > MAX_STEP) ? MAX_STEP : m_step + 1;
            end else begin
                m_sl++; model_miss(1);
            end
        end else begin
            m_x = nx;
        end
    endtask

    // One clock edge: model follows the same edge, then settle 1 time unit.
    task automatic advance();
        @(posedge clk);
        m_tick = ((m_clk % 4) == 3);
        m_clk++;
        case (m_st)
            M_IDLE:  if (start) m_st = M_PLAY;
            M_OVER:  if (start) begin
                         m_sl = 0; m_sr = 0; m_dx = 1; m_dy = 1; m_step = 1; m_st = M_PLAY;
                     end
            M_PLAY:  if (m_tick) model_play_tick();
            M_POINT: if (m_tick) begin
                         m_pause++;
                         if (m_pause == 64) begin
                             m_pause = 0;
                             m_st = (m_sl == 9 || m_sr == 9) ? M_OVER : M_PLAY;
                         end
                     end
            default: m_st = M_IDLE;
        endcase
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (bx !== 10'd320 || by !== 10'd240 || sl !== 4'd0 || sr !== 4'd0 || go !== 1'b0) begin
            failures++;
            $display("FAIL reset_values got x=%0d y=%0d sl=%0d sr=%0d over=%0b want 320 240 0 0 0", bx, by, sl, sr, go);
        end
        #3 rst_n = 1'b1;
        model_reset();
        repeat (100) begin
            advance();
            checks++;
            if (bx !== 10'd320 || by !== 10'd240 || sl !== 4'd0 || sr !== 4'd0 || go !== 1'b0) begin
                failures++;
                $display("FAIL idle_hold t=%0t got x=%0d y=%0d sl=%0d sr=%0d over=%0b want 320 240 0 0 0", $time, bx, by, sl, sr, go);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bx !== 10'd320 || by !== 10'd240 || sl !== 4'd0 || sr !== 4'd0 || go !== 1'b0) begin
            failures++;
            $display("FAIL idle_async_reset got x=%0d y=%0d sl=%0d sr=%0d over=%0b want 320 240 0 0 0", bx, by, sl, sr, go);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_paddle_face();
        int offs[6];
        offs = '{10, -10, 11, -11, 0, 0};
        offs[4] = int'($urandom_range(20)) - 10;
        offs[5] = 12 + int'($urandom_range(30));
        foreach (offs[k]) begin
            int nt, ny, ndy, budget;
            bit expect_hit;
            do_reset();
            pl = 10'd10; pr = 10'd10;
            start = 1'b1; advance(); start = 1'b0;
            nt = 0; budget = 0;
            while (!(m_st == M_PLAY && m_dx > 0 && m_x + m_step >= 620) && budget < 2000) begin
                advance(); budget++;
                if (m_tick) nt++;
                checks++;
                if (bx !== 10'(m_x) || by !== 10'(m_y) || sl !== 4'(m_sl) || sr !== 4'(m_sr) || go !== (m_st == M_OVER)) begin
                    failures++;
                    $display("FAIL approach t=%0t got x=%0d y=%0d sl=%0d sr=%0d over=%0b want x=%0d y=%0d sl=%0d sr=%0d over=%0b",
                             $time, bx, by, sl, sr, go, m_x, m_y, m_sl, m_sr, m_st == M_OVER);
                end
                if (m_tick && nt == 239) begin
                    checks++;
                    if (by !== 10'd479) begin
                        failures++;
                        $display("FAIL bottom_wall got y=%0d want 479", by);
                    end
                end
            end
            checks++;
            if (budget >= 2000) begin
                failures++;
                $display("FAIL approach_timeout got budget=%0d want <2000", budget);
            end
            vnext(m_y, m_dy, m_step, ny, ndy);
            pr = 10'(clampv(ny + offs[k]));
            expect_hit = (iabs(int'(pr) - ny) <= 10);
            budget = 0;
            do begin
                advance(); budget++;
            end while (!m_tick && budget < 8);
            nt++;
            checks++;
            if (expect_hit && (bx !== 10'd620 || by !== 10'(ny) || sl !== 4'd0 || nt != 300)) begin
                failures++;
                $display("FAIL right_hit off=%0d got x=%0d y=%0d sl=%0d tick=%0d want 620 %0d 0 300", offs[k], bx, by, sl, nt, ny);
            end else if (!expect_hit && (bx !== 10'd320 || by !== 10'd240 || sl !== 4'd1)) begin
                failures++;
                $display("FAIL right_miss off=%0d got x=%0d y=%0d sl=%0d want 320 240 1", offs[k], bx, by, sl);
            end
            if (expect_hit) begin
                budget = 0;
                do begin
                    advance(); budget++;
                end while (!m_tick && budget < 8);
                checks++;
                if (bx !== 10'd619) begin
                    failures++;
                    $display("FAIL reflect_step got x=%0d want 619", bx);
                end
            end else begin
                nt = 0; budget = 0;
                while (bx === 10'd320 && budget < 400) begin
                    advance(); budget++;
                    if (m_tick) nt++;
                    checks++;
                    if (bx !== 10'(m_x) || by !== 10'(m_y) || sl !== 4'(m_sl) || sr !== 4'(m_sr) || go !== (m_st == M_OVER)) begin
                        failures++;
                        $display("FAIL point_pause t=%0t got x=%0d y=%0d sl=%0d sr=%0d over=%0b want x=%0d y=%0d sl=%0d sr=%0d over=%0b",
                                 $time, bx, by, sl, sr, go, m_x, m_y, m_sl, m_sr, m_st == M_OVER);
                    end
                end
                checks++;
                if (nt != 65 || bx !== 10'd321) begin
                    failures++;
                    $display("FAIL serve_after_pause got ticks=%0d x=%0d want 65 321", nt, bx);
                end
            end
        end
    endtask

    task automatic test_game_over();
        int budget;
        do_reset();
        pl = 10'd10; pr = 10'd10;
        start = 1'b1; advance(); start = 1'b0;
        budget = 0;
        while (m_st != M_OVER && budget < 30000) begin
            advance(); budget++;
            checks++;
            if (bx !== 10'(m_x) || by !== 10'(m_y) || sl !== 4'(m_sl) || sr !== 4'(m_sr) || go !== (m_st == M_OVER)) begin
                failures++;
                $display("FAIL match t=%0t got x=%0d y=%0d sl=%0d sr=%0d over=%0b want x=%0d y=%0d sl=%0d sr=%0d over=%0b",
                         $time, bx, by, sl, sr, go, m_x, m_y, m_sl, m_sr, m_st == M_OVER);
            end
        end
        checks++;
        if (budget >= 30000 || go !== 1'b1 || (sl !== 4'd9 && sr !== 4'd9)) begin
            failures++;
            $display("FAIL reach_over got over=%0b sl=%0d sr=%0d cycles=%0d want over=1 one score 9", go, sl, sr, budget);
        end
        repeat (800) begin
            pl = 10'($urandom_range(470, 10));
            pr = 10'($urandom_range(470, 10));
            advance();
            checks++;
            if (bx !== 10'd320 || by !== 10'd240 || go !== 1'b1 || sl !== 4'(m_sl) || sr !== 4'(m_sr)) begin
                failures++;
                $display("FAIL over_frozen t=%0t got x=%0d y=%0d over=%0b sl=%0d sr=%0d want 320 240 1 %0d %0d",
                         $time, bx, by, go, sl, sr, m_sl, m_sr);
            end
        end
        pl = 10'd10; pr = 10'd10;
        start = 1'b1; advance(); start = 1'b0;
        checks++;
        if (sl !== 4'd0 || sr !== 4'd0 || go !== 1'b0) begin
            failures++;
            $display("FAIL restart_clear got sl=%0d sr=%0d over=%0b want 0 0 0", sl, sr, go);
        end
        budget = 0;
        do begin
            advance(); budget++;
        end while (!m_tick && budget < 8);
        checks++;
        if (bx !== 10'd321 || by !== 10'd241) begin
            failures++;
            $display("FAIL restart_motion got x=%0d y=%0d want 321 241", bx, by);
        end
    endtask

    task automatic test_midplay_reset();
        int nt, budget;
        do_reset();
        pl = 10'($urandom_range(470, 10));
        pr = 10'($urandom_range(470, 10));
        start = 1'b1; advance(); start = 1'b0;
        nt = 0; budget = 0;
        while (nt < 150 && budget < 1000) begin
            advance(); budget++;
            if (m_tick) nt++;
            checks++;
            if (bx !== 10'(m_x) || by !== 10'(m_y) || sl !== 4'(m_sl) || sr !== 4'(m_sr) || go !== (m_st == M_OVER)) begin
                failures++;
                $display("FAIL pre_reset_play t=%0t got x=%0d y=%0d want x=%0d y=%0d", $time, bx, by, m_x, m_y);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bx !== 10'd320 || by !== 10'd240 || sl !== 4'd0 || sr !== 4'd0 || go !== 1'b0) begin
            failures++;
            $display("FAIL midplay_async_reset got x=%0d y=%0d sl=%0d sr=%0d over=%0b want 320 240 0 0 0", bx, by, sl, sr, go);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        repeat (50) begin
            advance();
            checks++;
            if (bx !== 10'd320 || by !== 10'd240 || go !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_idle t=%0t got x=%0d y=%0d over=%0b want 320 240 0", $time, bx, by, go);
            end
        end
        start = 1'b1; advance(); start = 1'b0;
        repeat (20) begin
            advance();
            checks++;
            if (bx !== 10'(m_x) || by !== 10'(m_y) || sl !== 4'(m_sl) || sr !== 4'(m_sr) || go !== (m_st == M_OVER)) begin
                failures++;
                $display("FAIL post_reset_play t=%0t got x=%0d y=%0d want x=%0d y=%0d", $time, bx, by, m_x, m_y);
            end
        end
    endtask

    task automatic test_speedup();
        int px, want_delta, last_hits, budget;
        do_reset();
        start = 1'b1; advance(); start = 1'b0;
        want_delta = 0; last_hits = 0; budget = 0;
        while ((m_hits < 5 || want_delta != 0) && budget < 20000) begin
            pl = 10'(clampv(m_y));
            pr = 10'(clampv(m_y));
            px = int'(bx);
            advance(); budget++;
            checks++;
            if (bx !== 10'(m_x) || by !== 10'(m_y) || sl !== 4'(m_sl) || sr !== 4'(m_sr) || go !== (m_st == M_OVER)) begin
                failures++;
                $display("FAIL rally t=%0t got x=%0d y=%0d sl=%0d sr=%0d want x=%0d y=%0d sl=%0d sr=%0d",
                         $time, bx, by, sl, sr, m_x, m_y, m_sl, m_sr);
            end
            if (m_tick && want_delta != 0) begin
                checks++;
                if (iabs(int'(bx) - px) != want_delta) begin
                    failures++;
                    $display("FAIL step_after_hit hits=%0d got dx=%0d want %0d", last_hits, iabs(int'(bx) - px), want_delta);
                end
                want_delta = 0;
            end
            if (m_hits != last_hits) begin
                last_hits  = m_hits;
                want_delta = (m_hits + 1 > MAX_STEP) ? MAX_STEP : m_hits + 1;
            end
        end
        checks++;
        if (budget >= 20000) begin
            failures++;
            $display("FAIL rally_timeout got hits=%0d want 5", m_hits);
        end
        budget = 0;
        while (m_st != M_PLAY || m_x != 320 || !m_tick) begin
            if (budget >= 3000) break;
            pl = (m_y < 240) ? 10'd470 : 10'd10;
            pr = (m_y < 240) ? 10'd470 : 10'd10;
            px = int'(bx);
            advance(); budget++;
            checks++;
            if (bx !== 10'(m_x) || by !== 10'(m_y) || sl !== 4'(m_sl) || sr !== 4'(m_sr) || go !== (m_st == M_OVER)) begin
                failures++;
                $display("FAIL miss_rally t=%0t got x=%0d y=%0d sl=%0d sr=%0d want x=%0d y=%0d sl=%0d sr=%0d",
                         $time, bx, by, sl, sr, m_x, m_y, m_sl, m_sr);
            end
            if (m_tick && m_st == M_PLAY && px == 320 && m_x != 320) begin
                checks++;
                if (iabs(int'(bx) - px) != 1) begin
                    failures++;
                    $display("FAIL step_after_miss got dx=%0d want 1", iabs(int'(bx) - px));
                end
                break;
            end
        end
        checks++;
        if (budget >= 3000) begin
            failures++;
            $display("FAIL miss_timeout got cycles=%0d want <3000", budget);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_paddle_face();
        test_game_over();
        test_midplay_reset();
        test_speedup();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog got time=%0t want finish earlier", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
